byte_permutation_stream: RTL and testbench

- Parametrised, handshaked, byte-serial ShiftRows / InvShiftRows engine for the low-area AES datapath; successor to the fixed 4-column byte permutation stage.
- Accepts a Rijndael state one element per beat in column-major order (k = row + 4*col) and emits the row-rotated state in the same order.
- Uses a ping-pong buffer, so block n drains while block n+1 fills.
- Sits between the serial S-box and the serial MixColumns stage.

---
 rtl/byte_permutation_stream.sv | 159 +++++++++++++++
 tb/tb_byte_permutation_stream.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_permutation_stream.sv
// Byte-serial ShiftRows / InvShiftRows engine with a ping-pong pair of N-element banks.
// Optional build macro BYTE_PERM_BYPASS_EN adds a per-block bypass (unpermuted) input.
module byte_permutation_stream #(
  parameter int DW = 8,
  parameter int NB = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          mode,
`ifdef BYTE_PERM_BYPASS_EN
  input  logic          bypass,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  localparam int N  = 4 * NB;
  localparam int AW = $clog2(N);
  localparam int CW = AW - 2;
  localparam int SW = CW + 2;
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [SW-1:0] NB_W = SW'(NB);

  // Bit 1 set means the bank holds a complete block (FULL or DRAINING)
  localparam logic [1:0] ST_EMPTY    = 2'd0;
  localparam logic [1:0] ST_FILLING  = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;
  localparam logic [1:0] ST_DRAINING = 2'd3;

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("byte_permutation_stream: NB must be 4, 6 or 8 (got %0d)", NB);
  end

  logic          byp_in;
  logic [1:0]    bank_state [2];
  logic [DW-1:0] bank_dout  [2];
  logic          wr_bank_reg, rd_bank_reg;
  logic [AW-1:0] wr_cnt_reg, rd_cnt_reg;
  logic [DW-1:0] hold_reg;
  logic          wr_fire, rd_fire;
  logic [1:0]    row;
  logic [CW-1:0] col;
  logic [2:0]    shift;
  logic [SW-1:0] fwd_sum, inv_sum;
  logic [CW-1:0] fwd_col, inv_col;

`ifdef BYTE_PERM_BYPASS_EN
  assign byp_in = bypass;
`else
  assign byp_in = 1'b0;
`endif

  assign in_ready  = ~bank_state[wr_bank_reg][1];
  assign out_valid = bank_state[rd_bank_reg][1];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  assign row = rd_cnt_reg[1:0];
  assign col = rd_cnt_reg[AW-1:2];

  always_comb begin
    case (row)
      2'd0:    shift = 3'd0;
      2'd1:    shift = 3'd1;
      2'd2:    shift = (NB == 8) ? 3'd3 : 3'd2;
      default: shift = (NB == 8) ? 3'd4 : 3'd3;
    endcase
  end

  // Both sums stay below 2*NB, so one conditional subtract is an exact modulo
  assign fwd_sum = SW'(col) + SW'(shift);
  assign inv_sum = SW'(col) + NB_W - SW'(shift);
  assign fwd_col = CW'((fwd_sum >= NB_W) ? (fwd_sum - NB_W) : fwd_sum);
  assign inv_col = CW'((inv_sum >= NB_W) ? (inv_sum - NB_W) : inv_sum);

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [1:0]    state_reg;
    logic          mode_reg;
    logic          byp_reg;
    logic [DW-1:0] mem_reg [N];
    logic          wr_hit, rd_hit;
    logic [AW-1:0] rd_idx;

    assign wr_hit = wr_fire && (wr_bank_reg == 1'(gi));
    assign rd_hit = rd_fire && (rd_bank_reg == 1'(gi));
    assign rd_idx = byp_reg ? rd_cnt_reg : {(mode_reg ? inv_col : fwd_col), row};
    assign bank_state[gi] = state_reg;
    assign bank_dout[gi]  = mem_reg[rd_idx];

    // A bank is never written and read in the same cycle: the states are disjoint
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_reg <= ST_EMPTY;
        mode_reg  <= 1'b0;
        byp_reg   <= 1'b0;
        for (int i = 0; i < N; i++) mem_reg[i] <= '0;
      end else if (flush) begin
        state_reg <= ST_EMPTY;
        mode_reg  <= 1'b0;
        byp_reg   <= 1'b0;
        for (int i = 0; i < N; i++) mem_reg[i] <= '0;
      end else if (wr_hit) begin
        mem_reg[wr_cnt_reg] <= in_data;
        if (wr_cnt_reg == '0) begin
          mode_reg <= mode;
          byp_reg  <= byp_in;
        end
        state_reg <= (wr_cnt_reg == LAST) ? ST_FULL : ST_FILLING;
      end else if (rd_hit) begin
        state_reg <= (rd_cnt_reg == LAST) ? ST_EMPTY : ST_DRAINING;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      wr_cnt_reg  <= '0;
      rd_cnt_reg  <= '0;
      hold_reg    <= '0;
    end else if (flush) begin
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      wr_cnt_reg  <= '0;
      rd_cnt_reg  <= '0;
      hold_reg    <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt_reg == LAST) begin
          wr_cnt_reg  <= '0;
          wr_bank_reg <= ~wr_bank_reg;
        end else begin
          wr_cnt_reg <= wr_cnt_reg + 1'b1;
        end
      end
      if (rd_fire) begin
        hold_reg <= out_data;
        if (rd_cnt_reg == LAST) begin
          rd_cnt_reg  <= '0;
          rd_bank_reg <= ~rd_bank_reg;
        end else begin
          rd_cnt_reg <= rd_cnt_reg + 1'b1;
        end
      end
    end
  end

  // When idle the output holds the last element actually transferred
  assign out_data = out_valid ? bank_dout[rd_bank_reg] : hold_reg;
  assign out_last = out_valid && (rd_cnt_reg == LAST);

endmodule

// File: tb/tb_byte_permutation_stream.sv
// Self-checking bench for byte_permutation_stream: NB=4 and NB=8 instances against a row-rotation model.
// Define BYTE_PERM_BYPASS_EN for both bench and design to cover the bypass build.
module tb_byte_permutation_stream;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic [7:0] d; logic m; logic b;} beat_t;

  localparam logic [7:0] SR_EXP  [16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                                         8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
  localparam logic [7:0] ISR_EXP [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                                         8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, mode = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, sel8 = 1'b0;
  logic [7:0] in_data = 8'h00;
`ifdef BYTE_PERM_BYPASS_EN
  logic bypass = 1'b0;
`endif
  logic iv4, iv8, ir4, ir8, ov4, ov8, ol4, ol8;
  logic [7:0] od4, od8;
  logic cur_ir, cur_ov, cur_ol;
  logic [7:0] cur_od;

  int checks = 0, failures = 0, cyc = 0;
  int acc_cnt, last_acc_cyc, first_ov_cyc, acc_at_hold, stall_bad;
  logic ir_at_hold;
  beat_t src_q[$];
  bq_t got_q, exp_q;
  logic last_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign iv4 = in_valid & ~sel8;
  assign iv8 = in_valid & sel8;
  assign cur_ir = sel8 ? ir8 : ir4;
  assign cur_ov = sel8 ? ov8 : ov4;
  assign cur_ol = sel8 ? ol8 : ol4;
  assign cur_od = sel8 ? od8 : od4;

  byte_permutation_stream #(.DW(8), .NB(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .mode(mode),
`ifdef BYTE_PERM_BYPASS_EN
    .bypass(bypass),
`endif
    .in_valid(iv4), .in_ready(ir4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .out_last(ol4)
  );

  byte_permutation_stream #(.DW(8), .NB(8)) dut8 (
    .clk(clk), .rst(rst), .flush(flush), .mode(mode),
`ifdef BYTE_PERM_BYPASS_EN
    .bypass(bypass),
`endif
    .in_valid(iv8), .in_ready(ir8), .in_data(in_data),
    .out_valid(ov8), .out_ready(out_ready), .out_data(od8), .out_last(ol8)
  );

  // Reference: each row r of the 4 x nb matrix is rotated left (mode 0) or right (mode 1) by s(r)
  function automatic bq_t permute(input bq_t blk, input bit m, input bit byp, input int nb);
    bq_t res;
    logic [7:0] rq[$];
    int s;
    res = blk;
    if (byp) return res;
    for (int r = 0; r < 4; r++) begin
      s = (nb == 8 && r >= 2) ? r + 1 : r;
      rq.delete();
      for (int c = 0; c < nb; c++) rq.push_back(blk[r + 4 * c]);
      for (int k = 0; k < s; k++) begin
        if (!m) rq.push_back(rq.pop_front());
        else    rq.push_front(rq.pop_back());
      end
      for (int c = 0; c < nb; c++) res[r + 4 * c] = rq[c];
    end
    return res;
  endfunction

  function automatic bq_t seq_block(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(i));
    return q;
  endfunction

  function automatic bq_t rand_block(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
    return q;
  endfunction

  task automatic clear_q();
    src_q.delete(); got_q.delete(); exp_q.delete(); last_q.delete();
  endtask

  // Mode/bypass on beats after the first are randomised: they must be ignored
  task automatic add_block(input bq_t blk, input bit m, input bit byp, input int nb);
    bq_t p;
    beat_t bt;
    for (int i = 0; i < blk.size(); i++) begin
      bt.d = blk[i];
      bt.m = (i == 0) ? m : 1'($urandom_range(1));
      bt.b = (i == 0) ? byp : 1'($urandom_range(1));
      src_q.push_back(bt);
    end
    p = permute(blk, m, byp, nb);
    foreach (p[i]) exp_q.push_back(p[i]);
  endtask

  // Cycle-based driver/collector; entered and left at a falling edge
  task automatic run_stream(input int exp_n, input int in_pct, input int out_pct,
                            input int hold, input int max_cyc, output bit timeout);
    bit pstall = 0;
    logic [7:0] pd = 8'h00;
    logic pl = 1'b0;
    acc_cnt = 0; last_acc_cyc = -1; first_ov_cyc = -1; acc_at_hold = -1;
    stall_bad = 0; ir_at_hold = 1'bx; timeout = 0;
    for (int c = 0; got_q.size() < exp_n; c++) begin
      if (c >= max_cyc) begin timeout = 1; break; end
      in_valid = (src_q.size() > 0) && ($urandom_range(99) < in_pct);
      if (in_valid) begin
        in_data = src_q[0].d;
        mode    = src_q[0].m;
`ifdef BYTE_PERM_BYPASS_EN
        bypass  = src_q[0].b;
`endif
      end
      out_ready = (c >= hold) && ($urandom_range(99) < out_pct);
      #1;
      if (pstall && (cur_od !== pd || cur_ol !== pl || cur_ov !== 1'b1)) stall_bad++;
      if (cur_ov && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (in_valid && cur_ir) begin
        void'(src_q.pop_front());
        acc_cnt++;
        last_acc_cyc = cyc;
      end
      if (c == hold - 1) begin acc_at_hold = acc_cnt; ir_at_hold = cur_ir; end
      if (cur_ov && out_ready) begin
        got_q.push_back(cur_od);
        last_q.push_back(cur_ol);
      end
      pstall = cur_ov && !out_ready;
      pd = cur_od;
      pl = cur_ol;
      @(negedge clk);
    end
    in_valid = 0;
    out_ready = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (ir4 !== 1'b1 || ir8 !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got %b/%b expected 1/1", ir4, ir8);
    end
    @(negedge clk);
    checks++;
    if (ov4 !== 1'b0 || ov8 !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got %b/%b expected 0/0", ov4, ov8);
    end
    checks++;
    if (od4 !== 8'h00 || od8 !== 8'h00) begin
      failures++; $display("FAIL reset_out_data got %02h/%02h expected 00/00", od4, od8);
    end
    checks++;
    if (ol4 !== 1'b0 || ol8 !== 1'b0) begin
      failures++; $display("FAIL reset_out_last got %b/%b expected 0/0", ol4, ol8);
    end
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_shift_rows();
    bit to;
    clear_q(); sel8 = 0;
    add_block(seq_block(16), 1'b0, 1'b0, 4);
    run_stream(16, 100, 100, 0, 200, to);
    checks++;
    if (to || got_q.size() != 16) begin
      failures++; $display("FAIL sr_count got %0d expected 16", got_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got_q[i] !== SR_EXP[i]) begin
          failures++; $display("FAIL sr_data[%0d] got %02h expected %02h", i, got_q[i], SR_EXP[i]);
        end
        checks++;
        if (last_q[i] !== 1'(i == 15)) begin
          failures++; $display("FAIL sr_last[%0d] got %b expected %b", i, last_q[i], i == 15);
        end
      end
    end
    checks++;
    if (first_ov_cyc != last_acc_cyc + 1) begin
      failures++; $display("FAIL sr_latency got first_valid_cycle=%0d expected %0d", first_ov_cyc, last_acc_cyc + 1);
    end
    $display("test_shift_rows done checks=%0d", checks);
  endtask

  task automatic test_inv_shift_rows();
    bit to;
    bq_t fwd;
    clear_q(); sel8 = 0;
    add_block(seq_block(16), 1'b1, 1'b0, 4);
    add_block(seq_block(16), 1'b0, 1'b0, 4);
    run_stream(32, 100, 100, 0, 300, to);
    checks++;
    if (to || got_q.size() != 32) begin
      failures++; $display("FAIL isr_count got %0d expected 32", got_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got_q[i] !== ISR_EXP[i]) begin
          failures++; $display("FAIL isr_data[%0d] got %02h expected %02h", i, got_q[i], ISR_EXP[i]);
        end
      end
      fwd = got_q[16:31];
      clear_q();
      add_block(fwd, 1'b1, 1'b0, 4);
      run_stream(16, 100, 100, 0, 200, to);
      checks++;
      if (to || got_q.size() != 16) begin
        failures++; $display("FAIL roundtrip4_count got %0d expected 16", got_q.size());
      end else begin
        for (int i = 0; i < 16; i++) begin
          checks++;
          if (got_q[i] !== 8'(i)) begin
            failures++; $display("FAIL roundtrip4[%0d] got %02h expected %02h", i, got_q[i], 8'(i));
          end
        end
      end
    end
    $display("test_inv_shift_rows done checks=%0d", checks);
  endtask

  task automatic test_nb8();
    bit to;
    bq_t d, inv;
    clear_q(); sel8 = 1;
    add_block(seq_block(32), 1'b0, 1'b0, 8);
    run_stream(32, 100, 100, 0, 300, to);
    checks++;
    if (to || got_q.size() != 32) begin
      failures++; $display("FAIL nb8_count got %0d expected 32", got_q.size());
    end else begin
      checks++;
      if (got_q[1] !== 8'h05 || got_q[2] !== 8'h0E || got_q[3] !== 8'h13) begin
        failures++; $display("FAIL nb8_rows got %02h %02h %02h expected 05 0E 13", got_q[1], got_q[2], got_q[3]);
      end
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i] || last_q[i] !== 1'(i == 31)) begin
          failures++; $display("FAIL nb8_data[%0d] got %02h/%b expected %02h/%b", i, got_q[i], last_q[i], exp_q[i], i == 31);
        end
      end
    end
    d = rand_block(32);
    clear_q();
    add_block(d, 1'b1, 1'b0, 8);
    run_stream(32, 80, 80, 0, 600, to);
    inv = got_q;
    clear_q();
    add_block(inv, 1'b0, 1'b0, 8);
    run_stream(32, 80, 80, 0, 600, to);
    checks++;
    if (to || got_q.size() != 32) begin
      failures++; $display("FAIL nb8_roundtrip_count got %0d expected 32", got_q.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (got_q[i] !== d[i]) begin
          failures++; $display("FAIL nb8_roundtrip[%0d] got %02h expected %02h", i, got_q[i], d[i]);
        end
      end
    end
    sel8 = 0;
    $display("test_nb8 done checks=%0d", checks);
  endtask

  task automatic test_backpressure();
    bit to;
    clear_q(); sel8 = 0;
    for (int b = 0; b < 3; b++) add_block(rand_block(16), 1'($urandom_range(1)), 1'b0, 4);
    run_stream(48, 100, 100, 40, 400, to);
    checks++;
    if (acc_at_hold != 32) begin
      failures++; $display("FAIL bp_accepted got %0d expected 32", acc_at_hold);
    end
    checks++;
    if (ir_at_hold !== 1'b0) begin
      failures++; $display("FAIL bp_in_ready got %b expected 0", ir_at_hold);
    end
    checks++;
    if (stall_bad != 0) begin
      failures++; $display("FAIL bp_stable got %0d unstable cycles expected 0", stall_bad);
    end
    checks++;
    if (to || got_q.size() != 48) begin
      failures++; $display("FAIL bp_count got %0d expected 48", got_q.size());
    end else begin
      for (int i = 0; i < 48; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i] || last_q[i] !== 1'((i % 16) == 15)) begin
          failures++; $display("FAIL bp_data[%0d] got %02h/%b expected %02h/%b", i, got_q[i], last_q[i], exp_q[i], (i % 16) == 15);
        end
      end
    end
    $display("test_backpressure done checks=%0d", checks);
  endtask

  task automatic test_random();
    bit to;
    int n, nb, nblk;
    for (int pass = 0; pass < 2; pass++) begin
      clear_q();
      sel8 = 1'(pass);
      nb = pass ? 8 : 4;
      n = 4 * nb;
      nblk = pass ? 4 : 6;
      for (int b = 0; b < nblk; b++) add_block(rand_block(n), 1'($urandom_range(1)), 1'b0, nb);
      run_stream(n * nblk, 70, 60, 0, 3000, to);
      checks++;
      if (stall_bad != 0) begin
        failures++; $display("FAIL rand%0d_stable got %0d unstable cycles expected 0", nb, stall_bad);
      end
      checks++;
      if (to || got_q.size() != n * nblk) begin
        failures++; $display("FAIL rand%0d_count got %0d expected %0d", nb, got_q.size(), n * nblk);
      end else begin
        for (int i = 0; i < n * nblk; i++) begin
          checks++;
          if (got_q[i] !== exp_q[i] || last_q[i] !== 1'((i % n) == n - 1)) begin
            failures++; $display("FAIL rand%0d_data[%0d] got %02h/%b expected %02h/%b", nb, i, got_q[i], last_q[i], exp_q[i], (i % n) == n - 1);
          end
        end
      end
    end
    sel8 = 0;
    $display("test_random done checks=%0d", checks);
  endtask

  task automatic test_mid_block_clear(input bit use_flush);
    bit to;
    clear_q(); sel8 = 0; out_ready = 0;
    for (int k = 0; k < 23; k++) begin
      in_valid = 1; in_data = 8'(8'h40 + k); mode = 1'($urandom_range(1));
      @(negedge clk);
    end
    in_valid = 0;
    checks++;
    if (ov4 !== 1'b1) begin
      failures++; $display("FAIL clear_pre_valid got %b expected 1", ov4);
    end
    if (!use_flush) begin
      rst = 1;
      #1;
      checks++;
      if (ov4 !== 1'b0 || od4 !== 8'h00 || ol4 !== 1'b0) begin
        failures++; $display("FAIL rst_immediate got valid=%b data=%02h last=%b expected 0/00/0", ov4, od4, ol4);
      end
      @(negedge clk);
      rst = 0;
      #1;
    end else begin
      flush = 1; in_valid = 1; in_data = 8'hAA; out_ready = 1;
      @(posedge clk);
      #1;
      checks++;
      if (ov4 !== 1'b0 || od4 !== 8'h00 || ol4 !== 1'b0) begin
        failures++; $display("FAIL flush_clear got valid=%b data=%02h last=%b expected 0/00/0", ov4, od4, ol4);
      end
      @(negedge clk);
      flush = 0; in_valid = 0; out_ready = 0;
      #1;
    end
    checks++;
    if (ir4 !== 1'b1) begin
      failures++; $display("FAIL %s_in_ready got %b expected 1", use_flush ? "flush" : "rst", ir4);
    end
    @(negedge clk);
    add_block(seq_block(16), 1'b0, 1'b0, 4);
    run_stream(16, 100, 100, 0, 200, to);
    checks++;
    if (to || got_q.size() != 16) begin
      failures++; $display("FAIL %s_count got %0d expected 16", use_flush ? "flush" : "rst", got_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got_q[i] !== SR_EXP[i]) begin
          failures++; $display("FAIL %s_data[%0d] got %02h expected %02h", use_flush ? "flush" : "rst", i, got_q[i], SR_EXP[i]);
        end
      end
    end
    #1;
    checks++;
    if (ov4 !== 1'b0) begin
      failures++; $display("FAIL %s_no_leftover got valid=%b expected 0", use_flush ? "flush" : "rst", ov4);
    end
    @(negedge clk);
    $display("test_mid_block_clear(%s) done checks=%0d", use_flush ? "flush" : "rst", checks);
  endtask

`ifdef BYTE_PERM_BYPASS_EN
  task automatic test_bypass();
    bit to;
    clear_q(); sel8 = 0;
    add_block(seq_block(16), 1'b0, 1'b1, 4);
    add_block(seq_block(16), 1'b0, 1'b0, 4);
    run_stream(32, 100, 100, 0, 300, to);
    checks++;
    if (to || got_q.size() != 32) begin
      failures++; $display("FAIL byp_count got %0d expected 32", got_q.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (got_q[i] !== ((i < 16) ? 8'(i) : SR_EXP[i - 16])) begin
          failures++; $display("FAIL byp_data[%0d] got %02h expected %02h", i, got_q[i], (i < 16) ? 8'(i) : SR_EXP[i - 16]);
        end
      end
    end
    $display("test_bypass done checks=%0d", checks);
  endtask
`endif

  initial begin
    test_reset();
    test_shift_rows();
    test_inv_shift_rows();
    test_nb8();
    test_backpressure();
    test_random();
    test_mid_block_clear(1'b0);
    test_mid_block_clear(1'b1);
`ifdef BYTE_PERM_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
